muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle RV32M multiply/divide execution unit in EX.
- Accepts an operation when the decoded control word has muldiv_en set, and computes it iteratively.
- Returns the result with a one-cycle done pulse; the hazard logic stalls the pipeline while busy is high.
- Covers all eight M-extension funct3 encodings.

Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  request; EX valid AND ctrl.muldiv_en
- funct3  input  3  0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu
- rs1_val  input  WIDTH  operand A (dividend / multiplicand)
- rs2_val  input  WIDTH  operand B (divisor / multiplier)
- flush  input  1  abort the in-flight operation (branch mispredict)
- busy  output  1  high from the cycle after acceptance through the done cycle
- done  output  1  one-cycle pulse; result valid in this cycle
- result  output  WIDTH  final result; held until the next acceptance

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, done=0, result=0, counter=0, all internal registers 0.
- States: IDLE, CALC, SPECIAL, FINISH.

IDLE:
- start=1 and flush=0 -> accept (cycle 0).
- Latch funct3.
- Latch sign flags:
  - A signed for mulh, mulhsu, div, rem.
  - B signed for mulh, div, rem.
- Latch operand magnitudes (two's-complement absolute value when the sign flag is set and the MSB is 1).
- Clear the 2*WIDTH accumulator and set counter=0.
- Next state is SPECIAL if the operation is a divide/remainder AND (B==0 OR (signed div/rem AND A==0x80000000 AND B==0xFFFFFFFF)); otherwise CALC.

CALC: one iteration per cycle, counter++. Leave CALC after counter reaches WIDTH, so CALC spans cycles 1..32.
- Multiply: shift-add. If multiplier LSB=1, add the multiplicand into the upper half; shift the accumulator right by 1; shift the multiplier right by 1.
- Divide: restoring. Shift the {rem, quo} pair left by 1; if rem >= divisor, subtract and set quotient LSB=1.

FINISH (cycle 33): done=1, busy=1; result is registered this cycle. Next state IDLE. Latency is 33 cycles from acceptance to the done cycle.
- Sign fix-up:
  - Product negated if signA XOR signB.
  - Quotient negated if signA XOR signB.
  - Remainder takes the sign of the dividend.
- Result selection:
  - mul: low WIDTH bits of the product.
  - mulh, mulhsu, mulhu: high WIDTH bits.
  - div, divu: quotient.
  - rem, remu: remainder.

SPECIAL (cycle 1): done=1, busy=1; next state IDLE.
- Divide by zero: quotient = all ones; remainder = original rs1_val.
- Signed overflow: quotient = 0x80000000; remainder = 0.

Boundary and concurrency rules:
- start while busy is ignored; operands are not re-latched.
- start in the same cycle as done is also ignored; acceptance happens only in IDLE.
- flush in any non-IDLE state -> IDLE next cycle; no done pulse; result keeps its previous value.
- flush has priority over done: a flush in FINISH/SPECIAL suppresses done and the result update.
- flush together with start in IDLE -> not accepted.
- Reset mid-operation -> immediate return to reset values; no done afterwards.
- Operands of 0 take the normal CALC path. mul by 0 yields 0 after 33 cycles; no early exit.
- Counter never exceeds WIDTH; no wrap.

Test Plan:
- Reset, then mul with A=7, B=0xFFFFFFFD (-3) -> busy high for cycles 1..33; done only in cycle 33; result=0xFFFFFFEB.
- mulhu with A=B=0xFFFFFFFF -> result=0xFFFFFFFE at cycle 33. mulh with the same operands -> result=0x00000000.
- div with A=0xFFFFFFF9 (-7), B=2 -> result=0xFFFFFFFD. rem with the same operands -> result=0xFFFFFFFF. remu with A=7, B=2 -> result=1.
- divu with A=5, B=0 -> done in cycle 1, result=0xFFFFFFFF. rem with A=5, B=0 -> result=5. div with A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, done in cycle 1.
- mul accepted, then flush at cycle 10 with start held -> no done pulse; busy=0 at cycle 11; result unchanged. A new start at cycle 11 is accepted and its done arrives at cycle 44.
- rst driven low asynchronously mid-CALC (between clock edges) -> busy, done, result read 0 immediately. A start during busy is ignored: a second start at cycle 5 does not alter the first result.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one iteration per cycle, with a one-cycle done pulse and flush abort.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CALC    = 2'd1;
  localparam logic [1:0] S_SPECIAL = 2'd2;
  localparam logic [1:0] S_FINISH  = 2'd3;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state;
  logic [2:0]         fn;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   orig_a;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   counter;
  logic [WIDTH-1:0]   result_q;

  // Operand decode for the accepting cycle.
  logic             is_div_in;
  logic             a_signed_in;
  logic             b_signed_in;
  logic             a_neg_in;
  logic             b_neg_in;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic             div_ovf_in;
  logic             to_special;

  assign is_div_in   = funct3[2];
  assign a_signed_in = (funct3 == 3'd1) || (funct3 == 3'd2) ||
                       (funct3 == 3'd4) || (funct3 == 3'd6);
  assign b_signed_in = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
  assign a_neg_in    = a_signed_in && rs1_val[WIDTH-1];
  assign b_neg_in    = b_signed_in && rs2_val[WIDTH-1];
  assign mag_a_in    = a_neg_in ? -rs1_val : rs1_val;
  assign mag_b_in    = b_neg_in ? -rs2_val : rs2_val;
  assign div_ovf_in  = is_div_in && !funct3[0] &&
                       (rs1_val == MIN_NEG) && (rs2_val == {WIDTH{1'b1}});
  assign to_special  = is_div_in && ((rs2_val == '0) || div_ovf_in);

  // One shift-add multiply step; the carry out of the upper half is shifted back in.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mag_b[0] ? {1'b0, mag_a} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // One restoring divide step; the dividend is fed MSB-first out of mag_a.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_sub;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = {acc[2*WIDTH-1:WIDTH], mag_a[WIDTH-1]};
  assign div_sub   = div_shift - {1'b0, mag_b};
  assign div_ge    = (div_shift >= {1'b0, mag_b});
  assign div_rem   = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc[WIDTH-2:0], div_ge};

  // Sign fix-up and result selection.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   calc_res;
  logic [WIDTH-1:0]   special_res;
  logic [WIDTH-1:0]   fin_res;

  assign prod_fix = (neg_a ^ neg_b) ? -acc : acc;
  assign quo_fix  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // NOTE: every output of a combinational block gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    calc_res = '0;
    case (fn)
      3'd0:             calc_res = prod_fix[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: calc_res = prod_fix[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:       calc_res = quo_fix;
      default:          calc_res = rem_fix;
    endcase
  end

  // A zero divisor is the only case whose latched magnitude is zero.
  always_comb begin
    special_res = '0;
    if (mag_b == '0) begin
      special_res = fn[1] ? orig_a : {WIDTH{1'b1}};
    end else begin
      special_res = fn[1] ? '0 : MIN_NEG;
    end
  end

  assign fin_res = (state == S_SPECIAL) ? special_res : calc_res;
  assign busy    = (state != S_IDLE);
  assign done    = ((state == S_FINISH) || (state == S_SPECIAL)) && !flush;
  assign result  = done ? fin_res : result_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      fn       <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      orig_a   <= '0;
      acc      <= '0;
      counter  <= '0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            fn      <= funct3;
            neg_a   <= a_neg_in;
            neg_b   <= b_neg_in;
            mag_a   <= mag_a_in;
            mag_b   <= mag_b_in;
            orig_a  <= rs1_val;
            acc     <= '0;
            counter <= '0;
            state   <= to_special ? S_SPECIAL : S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            if (fn[2]) begin
              acc   <= div_next;
              mag_a <= mag_a << 1;
            end else begin
              acc   <= mul_next;
              mag_b <= mag_b >> 1;
            end
            counter <= counter + CNT_W'(1);
            if (counter == CNT_W'(WIDTH - 1)) begin
              state <= S_FINISH;
            end
          end
        end
        default: begin
          // FINISH and SPECIAL: a flush in this cycle drops the result.
          state <= S_IDLE;
          if (!flush) begin
            result_q <= fin_res;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random operations
// against an arithmetic reference model, and flush/reset/busy corner sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_res;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Reference model: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ub, q, r;
    logic [63:0] p;
    logic        ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0];  end
      3'd1: begin p = sa * sb;                 return p[63:32]; end
      3'd2: begin p = sa * ub;                 return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        q = sa / sb;
        return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        r = sa % sb;
        return r[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f >= 3'd4 && (b == 0 || ((f == 3'd4 || f == 3'd6) &&
                                 a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic add_vec(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endtask

  // Issue one operation, wait (bounded) for done, check latency, result, busy.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input string name);
    int          c;
    bit          seen;
    bit          busy_bad;
    logic [31:0] got;
    @(negedge clk);
    funct3 = f; rs1_val = a; rs2_val = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1; seen = 1'b0; busy_bad = 1'b0; got = 'x;
    while (c <= 60 && !seen) begin
      if (!busy) busy_bad = 1'b1;
      if (done) begin
        seen = 1'b1;
        got  = result;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    check_int({name, " latency"}, seen ? c : -1, exp_lat);
    check32({name, " result"}, got, exp_res);
    check_int({name, " busy low before done"}, int'(busy_bad), 0);
    @(negedge clk);
    check32({name, " idle after done"}, {30'd0, busy, done}, 32'd0);
    check32({name, " result held"}, result, exp_res);
    last_res = exp_res;
  endtask

  initial begin
    int          c;
    int          done_cnt;
    logic [31:0] f_exp;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0;
    last_res = '0;
    #2 rst = 1'b0;
    #1;
    check32("reset outputs", {busy, done, result[29:0]}, 32'd0);
    check32("reset result", result, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    add_vec(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul 7*-3");
    add_vec(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu -1*-1");
    add_vec(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh -1*-1");
    add_vec(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, "div -7/2");
    add_vec(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, "rem -7%2");
    add_vec(3'd7, 32'd7,          32'd2,         32'd1,         33, "remu 7%2");
    add_vec(3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "divu 5/0");
    add_vec(3'd6, 32'd5,          32'd0,         32'd5,         1,  "rem 5%0");
    add_vec(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  "div ovf");
    add_vec(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  "rem ovf");
    add_vec(3'd0, 32'd0,          32'd12345,     32'd0,         33, "mul by zero");
    add_vec(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu -1*max");
    foreach (vecs[i]) run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                             vecs[i].name);

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = rand_operand();
      rb = rand_operand();
      run_op(rf, ra, rb, ref_result(rf, ra, rb), ref_latency(rf, ra, rb),
             $sformatf("rand%0d f%0d %h %h", i, rf, ra, rb));
    end

    // Flush at cycle 10 with start held (and operands changing); restart at cycle 11.
    @(negedge clk);
    funct3 = 3'd0; rs1_val = 32'd1000; rs2_val = 32'd1000; start = 1'b1;
    for (c = 1; c <= 9; c++) begin
      @(negedge clk);
      rs1_val = 32'($urandom); rs2_val = 32'($urandom); funct3 = 3'd4;
    end
    @(negedge clk);
    flush = 1'b1;
    check32("flush cycle10 no done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check32("flush cycle11 busy", {31'd0, busy}, 32'd0);
    check32("flush result kept", result, last_res);
    flush = 1'b0; funct3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd5;
    @(negedge clk);
    start = 1'b0;
    c = 12;
    while (!done && c < 80) begin
      @(negedge clk);
      c++;
    end
    check_int("restart done cycle", c, 44);
    check32("restart result", result, 32'd15);
    last_res = 32'd15;

    // Start during busy at cycle 5, and start in the done cycle, are both ignored.
    f_exp = ref_result(3'd0, 32'd1234, 32'd5678);
    @(negedge clk);
    funct3 = 3'd0; rs1_val = 32'd1234; rs2_val = 32'd5678; start = 1'b1;
    c = 0;
    while (c < 60) begin
      @(negedge clk);
      c++;
      start = (c == 5);
      if (c == 5) begin
        funct3 = 3'd5; rs1_val = 32'd99; rs2_val = 32'd7;
      end
      if (done) break;
    end
    check_int("busy-start done cycle", c, 33);
    check32("busy-start result", result, f_exp);
    start = 1'b1; funct3 = 3'd5; rs1_val = 32'd100; rs2_val = 32'd0;
    @(negedge clk);
    start = 1'b0;
    check32("start in done cycle ignored", {30'd0, busy, done}, 32'd0);
    check32("result held after ignore", result, f_exp);
    last_res = f_exp;

    // Flush in FINISH and in SPECIAL suppresses done and the result update.
    run_op(3'd0, 32'd9, 32'd9, 32'd81, 33, "pre flush finish");
    @(negedge clk);
    funct3 = 3'd0; rs1_val = 32'd6; rs2_val = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    flush = 1'b1;
    #1;
    check32("flush in finish done", {30'd0, busy, done}, 32'd2);
    @(negedge clk);
    flush = 1'b0;
    check32("flush finish result", result, 32'd81);
    check32("flush finish idle", {31'd0, busy}, 32'd0);
    funct3 = 3'd5; rs1_val = 32'd3; rs2_val = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    #1;
    check32("flush in special done", {30'd0, busy, done}, 32'd2);
    @(negedge clk);
    flush = 1'b0;
    check32("flush special result", result, 32'd81);

    // Async reset mid-CALC, then no late done.
    @(negedge clk);
    funct3 = 3'd4; rs1_val = 32'd1000; rs2_val = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check32("mid reset busy/done", {30'd0, busy, done}, 32'd0);
    check32("mid reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check_int("no activity after reset", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
